serializador_tx: RTL and testbench

//  Dual-lane parallel-to-serial stage of phy_tx. Sits directly downstream of the registered lane

---
 rtl/serializador_tx_if.sv | 25 ++
 rtl/serializador_tx.sv | 107 ++++++++++
 tb/tb_serializador_tx.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/serializador_tx_if.sv
// Lane bundle of the dual-lane serializer: parallel lane bytes/valids in,
// serial bits plus the active/load status out.
interface serializador_tx_if #(
   parameter int unsigned DATA_W = 8
);
   logic [DATA_W-1:0] data_in0;
   logic [DATA_W-1:0] data_in1;
   logic              valid_in0;
   logic              valid_in1;
   logic              data_out0;
   logic              data_out1;
   logic              active;
   logic              load;

   // master: upstream lane stage plus whoever watches the serial side; slave: the serializer
   modport master (
      output data_in0, data_in1, valid_in0, valid_in1,
      input  data_out0, data_out1, active, load
   );

   modport slave (
      input  data_in0, data_in1, valid_in0, valid_in1,
      output data_out0, data_out1, active, load
   );
endinterface

// File: rtl/serializador_tx.sv
// Dual-lane parallel-to-serial stage of phy_tx: MSB-first shifting on clk_16f, comma fill
// on idle lanes, and a fixed comma preamble after reset so the receiver can align.
module serializador_tx #(
   parameter int unsigned       DATA_W     = 8,
   parameter logic [DATA_W-1:0] COMMA      = DATA_W'(8'hBC),
   parameter int unsigned       SYNC_BYTES = 4
) (
   input  logic             clk_16f,
   input  logic             reset,
   serializador_tx_if.slave bus
);
   localparam int unsigned       CNT_W     = $clog2(DATA_W);
   localparam int unsigned       SYNC_W    = $clog2(SYNC_BYTES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_W - 1);
   localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_BYTES);

   typedef enum logic {
      ST_SYNC   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [CNT_W-1:0]  bit_cnt;
   logic [SYNC_W-1:0] sync_cnt;
   logic [SYNC_W-1:0] sync_cnt_next;
   logic [DATA_W-1:0] shreg0;
   logic [DATA_W-1:0] shreg1;
   logic [DATA_W-1:0] byte0_next;
   logic [DATA_W-1:0] byte1_next;
   logic              active_q;
   logic              load_edge;

   // Shared by both lanes, so the two serial streams are always bit-aligned.
   assign load_edge = (bit_cnt == CNT_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk_16f or negedge reset) begin
      if (!reset) begin
         bit_cnt <= '0;
      end else if (load_edge) begin
         bit_cnt <= '0;
      end else begin
         bit_cnt <= bit_cnt + CNT_W'(1);
      end
   end

   // NOTE: next-state values get a default first, so no path through the case leaves
   // them unassigned and no latch is inferred.
   always_comb begin
      state_next    = state;
      sync_cnt_next = sync_cnt;
      case (state)
         ST_SYNC: begin
            if (load_edge) begin
               if (sync_cnt == SYNC_LAST) begin
                  state_next = ST_ACTIVE;
               end else begin
                  sync_cnt_next = sync_cnt + SYNC_W'(1);
               end
            end
         end
         ST_ACTIVE: begin
            state_next = ST_ACTIVE;
         end
         default: begin
            state_next = ST_SYNC;
         end
      endcase
   end

   // Selection follows state_next so the edge that ends the preamble already loads live data.
   assign byte0_next = ((state_next == ST_ACTIVE) && bus.valid_in0) ? bus.data_in0 : COMMA;
   assign byte1_next = ((state_next == ST_ACTIVE) && bus.valid_in1) ? bus.data_in1 : COMMA;

   always_ff @(posedge clk_16f or negedge reset) begin
      if (!reset) begin
         state    <= ST_SYNC;
         sync_cnt <= SYNC_W'(1);
         active_q <= 1'b0;
      end else begin
         state    <= state_next;
         sync_cnt <= sync_cnt_next;
         active_q <= (state_next == ST_ACTIVE);
      end
   end

   // Reset reloads commas, so a byte cut short by reset is dropped on the spot.
   always_ff @(posedge clk_16f or negedge reset) begin
      if (!reset) begin
         shreg0 <= COMMA;
         shreg1 <= COMMA;
      end else if (load_edge) begin
         shreg0 <= byte0_next;
         shreg1 <= byte1_next;
      end else begin
         shreg0 <= {shreg0[DATA_W-2:0], 1'b0};
         shreg1 <= {shreg1[DATA_W-2:0], 1'b0};
      end
   end

   assign bus.data_out0 = shreg0[DATA_W-1];
   assign bus.data_out1 = shreg1[DATA_W-1];
   assign bus.active    = active_q;
   assign bus.load      = load_edge;
endmodule

// File: tb/tb_serializador_tx.sv
// Directed bench for serializador_tx: preamble, lane selection table, back-to-back bytes,
// and reset in the middle of an ACTIVE byte.
module tb_serializador_tx;
   typedef struct {
      logic       v0;
      logic [7:0] d0;
      logic       v1;
      logic [7:0] d1;
      logic [7:0] e0;
      logic [7:0] e1;
   } vec_t;

   localparam logic [7:0] K = 8'hBC;

   logic clk_16f = 1'b0;
   logic reset   = 1'b0;
   int   total   = 0;
   int   bad     = 0;
   vec_t tbl [7];

   serializador_tx_if #(.DATA_W(8)) bus ();

   serializador_tx #(
      .DATA_W    (8),
      .COMMA     (8'hBC),
      .SYNC_BYTES(4)
   ) dut (
      .clk_16f(clk_16f),
      .reset  (reset),
      .bus    (bus)
   );

   always #5 clk_16f = ~clk_16f;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 8'h%02h, want 8'h%02h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b, want %b", name, act, exp);
      end
   endtask

   task automatic drive(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
      bus.valid_in0 = v0;
      bus.data_in0  = d0;
      bus.valid_in1 = v1;
      bus.data_in1  = d1;
   endtask

   // Samples one byte period on falling edges; optionally corrupts inputs after the load edge.
   task automatic capture(input bit scramble, output logic [7:0] b0, output logic [7:0] b1,
                          output logic [7:0] ld, output logic [7:0] act);
      b0  = '0;
      b1  = '0;
      ld  = '0;
      act = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_16f);
         b0  = {b0[6:0], bus.data_out0};
         b1  = {b1[6:0], bus.data_out1};
         ld  = {ld[6:0], bus.load};
         act = {act[6:0], bus.active};
         if (scramble && i == 0) begin
            bus.data_in0  = ~bus.data_in0;
            bus.data_in1  = ~bus.data_in1;
            bus.valid_in0 = ~bus.valid_in0;
            bus.valid_in1 = ~bus.valid_in1;
         end
      end
   endtask

   task automatic byte_check(input string tag, input bit scramble, input logic [7:0] e0,
                             input logic [7:0] e1, input logic [7:0] e_act);
      logic [7:0] b0, b1, ld, act;
      capture(scramble, b0, b1, ld, act);
      check({tag, ".lane0"}, b0, e0);
      check({tag, ".lane1"}, b1, e1);
      check({tag, ".load"}, ld, 8'h01);
      check({tag, ".active"}, act, e_act);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] n0, n1;

      tbl[0] = '{1'b1, 8'hA5, 1'b1, 8'h3C, 8'hA5, 8'h3C};
      tbl[1] = '{1'b1, 8'h00, 1'b0, 8'h77, 8'h00, K};
      tbl[2] = '{1'b1, 8'h01, 1'b0, 8'h00, 8'h01, K};
      tbl[3] = '{1'b1, 8'h80, 1'b0, 8'h00, 8'h80, K};
      tbl[4] = '{1'b0, 8'hFF, 1'b1, 8'hC3, K,     8'hC3};
      tbl[5] = '{1'b0, 8'h00, 1'b0, 8'h00, K,     K};
      tbl[6] = '{1'b1, 8'h5A, 1'b1, 8'h96, 8'h5A, 8'h96};

      drive(1'b0, 8'h00, 1'b0, 8'h00);
      repeat (3) @(negedge clk_16f);
      check_bit("rst.out0", bus.data_out0, 1'b1);
      check_bit("rst.out1", bus.data_out1, 1'b1);
      check_bit("rst.active", bus.active, 1'b0);
      check_bit("rst.load", bus.load, 1'b0);

      // Preamble: four commas whatever the lane inputs say.
      @(posedge clk_16f);
      #1 reset = 1'b1;
      byte_check("pre0", 1'b0, K, K, 8'h00);
      drive(1'b1, 8'hFF, 1'b0, 8'h00);
      byte_check("pre1", 1'b0, K, K, 8'h00);
      drive(1'b1, 8'hFF, 1'b1, 8'h11);
      byte_check("pre2", 1'b0, K, K, 8'h00);
      byte_check("pre3", 1'b0, K, K, 8'h00);

      // ACTIVE: table bytes back-to-back; inputs are corrupted between load edges.
      for (int i = 0; i < 7; i++) begin
         drive(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1);
         byte_check($sformatf("vec%0d", i), 1'b1, tbl[i].e0, tbl[i].e1, 8'hFF);
      end

      // Reset after bit 3 of an ACTIVE byte.
      drive(1'b1, 8'hA5, 1'b1, 8'h3C);
      n0 = '0;
      n1 = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_16f);
         n0 = {n0[2:0], bus.data_out0};
         n1 = {n1[2:0], bus.data_out1};
      end
      check("mid.lane0_head", {4'h0, n0}, 8'h0A);
      check("mid.lane1_head", {4'h0, n1}, 8'h03);
      reset = 1'b0;
      #1;
      check_bit("mid.rst_out0", bus.data_out0, 1'b1);
      check_bit("mid.rst_out1", bus.data_out1, 1'b1);
      check_bit("mid.rst_active", bus.active, 1'b0);
      check_bit("mid.rst_load", bus.load, 1'b0);

      drive(1'b1, 8'h00, 1'b1, 8'hFF);
      repeat (2) @(negedge clk_16f);
      @(posedge clk_16f);
      #1 reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         byte_check($sformatf("resync%0d", k), 1'b0, K, K, 8'h00);
      end
      drive(1'b1, 8'h0F, 1'b1, 8'hF0);
      byte_check("post", 1'b1, 8'h0F, 8'hF0, 8'hFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
